// File: rtl/fp16_divider_if.sv
// Operand/result bundle for the sequential FP16 divider.
// The master side issues operands; the slave side is the divider.
interface fp16_divider_if;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        i_vld;
  logic        o_busy;
  logic [15:0] o_res;
  logic        o_res_vld;
  logic        overflow;
  logic        underflow;
  logic        exception;

  modport master (
    output i_a, i_b, i_vld,
    input  o_busy, o_res, o_res_vld, overflow, underflow, exception
  );

  modport slave (
    input  i_a, i_b, i_vld,
    output o_busy, o_res, o_res_vld, overflow, underflow, exception
  );
endinterface

// File: rtl/fp16_divider.sv
// Sequential IEEE-754 half-precision divider: restoring mantissa division,
// one quotient bit per cycle, truncating, denormals flushed to zero.
module fp16_divider (
  input  logic          clk,
  input  logic          rst,
  fp16_divider_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [15:0]        r_a;
  logic [15:0]        r_b;
  logic [3:0]         r_cnt;
  logic [11:0]        r_rem;
  logic [11:0]        r_quot;
  logic [15:0]        r_res;
  logic               r_busy;
  logic               r_res_vld;
  logic               r_ovf;
  logic               r_udf;
  logic               r_exc;

  logic [4:0]         w_ea;
  logic [4:0]         w_eb;
  logic               w_a_nan;
  logic               w_a_inf;
  logic               w_a_zero;
  logic               w_b_nan;
  logic               w_b_inf;
  logic               w_b_zero;
  logic [11:0]        w_sig_b;
  logic               w_ge;
  logic [10:0]        w_rem_sub;
  logic               w_sign;
  logic [9:0]         w_mant;
  logic signed [6:0]  w_adj;
  logic signed [6:0]  w_exp;
  logic [15:0]        w_res;
  logic               w_ovf;
  logic               w_udf;
  logic               w_exc;

  assign w_ea     = r_a[14:10];
  assign w_eb     = r_b[14:10];
  assign w_a_nan  = (w_ea == 5'd31) && (r_a[9:0] != 10'd0);
  assign w_a_inf  = (w_ea == 5'd31) && (r_a[9:0] == 10'd0);
  assign w_a_zero = (w_ea == 5'd0);
  assign w_b_nan  = (w_eb == 5'd31) && (r_b[9:0] != 10'd0);
  assign w_b_inf  = (w_eb == 5'd31) && (r_b[9:0] == 10'd0);
  assign w_b_zero = (w_eb == 5'd0);

  // The partial remainder always stays below 2*divisor, so 12 bits suffice.
  assign w_sig_b   = {2'b01, r_b[9:0]};
  assign w_ge      = (r_rem >= w_sig_b);
  assign w_rem_sub = w_ge ? 11'(r_rem - w_sig_b) : r_rem[10:0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_vld) begin
          w_next = S_DIV;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_DIV: begin
        if (r_cnt == 4'd0) begin
          w_next = S_NORM;
        end else begin
          w_next = S_DIV;
        end
      end
      S_NORM:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Normalization, exponent and special-case resolution
  always_comb begin
    w_sign = r_a[15] ^ r_b[15];
    w_ovf  = 1'b0;
    w_udf  = 1'b0;
    w_exc  = 1'b0;
    w_res  = 16'h0000;
    if (r_quot[11]) begin
      w_mant = r_quot[10:1];
      w_adj  = 7'sd0;
    end else begin
      w_mant = r_quot[9:0];
      w_adj  = -7'sd1;
    end
    w_exp = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 7'sd15 + w_adj;
    if (w_a_nan || w_b_nan) begin
      w_res = 16'h7E00;
      w_exc = 1'b1;
    end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_res = 16'h7E00;
      w_exc = 1'b1;
    end else if (w_a_inf) begin
      w_res = {w_sign, 5'h1F, 10'h000};
    end else if (w_b_inf) begin
      w_res = {w_sign, 15'h0000};
    end else if (w_b_zero) begin
      w_res = {w_sign, 5'h1F, 10'h000};
      w_exc = 1'b1;
    end else if (w_a_zero) begin
      w_res = {w_sign, 15'h0000};
    end else if (w_exp >= 7'sd31) begin
      w_res = {w_sign, 5'h1F, 10'h000};
      w_ovf = 1'b1;
    end else if (w_exp <= 7'sd0) begin
      w_res = {w_sign, 15'h0000};
      w_udf = 1'b1;
    end else begin
      w_res = {w_sign, w_exp[4:0], w_mant};
    end
  end

  // Operand capture, quotient iteration and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= 16'h0000;
      r_b       <= 16'h0000;
      r_cnt     <= 4'd0;
      r_rem     <= 12'd0;
      r_quot    <= 12'd0;
      r_res     <= 16'h0000;
      r_busy    <= 1'b0;
      r_res_vld <= 1'b0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_exc     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_res_vld <= 1'b0;
          if (bus.i_vld) begin
            r_a    <= bus.i_a;
            r_b    <= bus.i_b;
            r_cnt  <= 4'd11;
            r_rem  <= {2'b01, bus.i_a[9:0]};
            r_quot <= 12'd0;
            r_busy <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_DIV: begin
          r_rem  <= {w_rem_sub, 1'b0};
          r_quot <= {r_quot[10:0], w_ge};
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_NORM: begin
          r_res     <= w_res;
          r_ovf     <= w_ovf;
          r_udf     <= w_udf;
          r_exc     <= w_exc;
          r_res_vld <= 1'b1;
        end
        S_DONE: begin
          r_res_vld <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: begin
          r_res_vld <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy    = r_busy;
  assign bus.o_res     = r_res;
  assign bus.o_res_vld = r_res_vld;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_udf;
  assign bus.exception = r_exc;
endmodule

// File: tb/tb_fp16_divider.sv
// Directed, table-driven bench for fp16_divider: results, flags, latency,
// busy-time input rejection, back-to-back acceptance and mid-operation reset.
module tb_fp16_divider;
  logic clk = 1'b0;
  logic rst;

  fp16_divider_if bus ();

  fp16_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
    logic        udf;
    logic        exc;
  } vec_t;

  vec_t vecs[20];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation from an idle divider and check result, flags and timing.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_res,
                        input logic eo, input logic eu, input logic ee, input bit junk,
                        input string name);
    int n;
    bit seen;
    bus.i_a   = a;
    bus.i_b   = b;
    bus.i_vld = 1'b1;
    @(posedge clk);
    #1;
    bus.i_vld = 1'b0;
    chk({name, " busy_at_accept"}, 32'(bus.o_busy), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (junk && n == 2) begin
        bus.i_a   = 16'h4000;
        bus.i_b   = 16'h3C00;
        bus.i_vld = 1'b1;
      end
      if (junk && n == 6) bus.i_vld = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (bus.o_res_vld) seen = 1'b1;
    end
    chk({name, " latency"}, 32'(n), 32'd13);
    chk({name, " res"}, 32'(bus.o_res), 32'(exp_res));
    chk({name, " flags"}, 32'({bus.overflow, bus.underflow, bus.exception}), 32'({eo, eu, ee}));
    chk({name, " busy_at_done"}, 32'(bus.o_busy), 32'd1);
    @(posedge clk);
    #1;
    chk({name, " vld_fall"}, 32'(bus.o_res_vld), 32'd0);
    chk({name, " busy_fall"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    int acc_edge[3];
    int acc_cnt;
    bit prev_busy;
    bit seen_vld;
    int n;

    vecs[0]  = '{16'hBC00, 16'h3C00, 16'hBC00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h4200, 16'h4000, 16'h3E00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'h4500, 16'h3C00, 16'h4500, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h7BFF, 16'h3800, 16'h7C00, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{16'h7800, 16'h3800, 16'h7C00, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{16'h7800, 16'h3C00, 16'h7800, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{16'h0400, 16'h7800, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{16'h0400, 16'h3C00, 16'h0400, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h0400, 16'h3C01, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{16'h3C00, 16'h0000, 16'h7C00, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{16'h0000, 16'h0000, 16'h7E00, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{16'h7C00, 16'h4000, 16'h7C00, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{16'h4000, 16'hFC00, 16'h8000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{16'h7E01, 16'h3C00, 16'h7E00, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{16'h7C00, 16'hFC00, 16'h7E00, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{16'h8000, 16'h4000, 16'h8000, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{16'h0001, 16'h3C00, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{16'hBC00, 16'h7C01, 16'h7E00, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{16'hC000, 16'h0000, 16'hFC00, 1'b0, 1'b0, 1'b1};

    bus.i_a   = 16'h0000;
    bus.i_b   = 16'h0000;
    bus.i_vld = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset res", 32'(bus.o_res), 32'h0);
    chk("reset busy", 32'(bus.o_busy), 32'd0);
    chk("reset vld", 32'(bus.o_res_vld), 32'd0);
    chk("reset flags", 32'({bus.overflow, bus.underflow, bus.exception}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].udf, vecs[i].exc,
             1'b0, $sformatf("vec%0d", i));
    end

    // Operands and i_vld presented while busy must not disturb the in-flight divide.
    run_op(16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0, 1'b0, 1'b1, "busy_ignore");

    // i_vld held high: accepts land only when the FSM is back in IDLE.
    bus.i_a   = 16'h4200;
    bus.i_b   = 16'h4000;
    bus.i_vld = 1'b1;
    acc_cnt   = 0;
    prev_busy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_busy && !prev_busy) begin
        if (acc_cnt < 3) acc_edge[acc_cnt] = k;
        acc_cnt++;
      end
      prev_busy = bus.o_busy;
    end
    bus.i_vld = 1'b0;
    n = 0;
    while (bus.o_busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold drain", 32'(bus.o_busy), 32'd0);
    chk("hold accept count", 32'(acc_cnt), 32'd3);
    if (acc_cnt >= 3) begin
      chk("hold accept0", 32'(acc_edge[0]), 32'd0);
      chk("hold accept1", 32'(acc_edge[1]), 32'd15);
      chk("hold accept2", 32'(acc_edge[2]), 32'd30);
    end
    chk("hold res", 32'(bus.o_res), 32'h3E00);

    // Reset in the middle of a divide aborts it with no result pulse.
    bus.i_a   = 16'h4200;
    bus.i_b   = 16'h4000;
    bus.i_vld = 1'b1;
    @(posedge clk);
    #1;
    bus.i_vld = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort res", 32'(bus.o_res), 32'h0);
    chk("abort busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen_vld = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_res_vld) seen_vld = 1'b1;
    end
    chk("abort no_vld", 32'(seen_vld), 32'd0);
    chk("abort idle", 32'(bus.o_busy), 32'd0);
    chk("abort res_hold", 32'(bus.o_res), 32'h0);

    run_op(16'h4200, 16'h4000, 16'h3E00, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
